pipe_hazard_ctl: RTL
====================

# pipe_hazard_ctl

Pipeline sequencing controller for the 32-bit core. Sits beside the decode stage and owns the stall and flush signals the datapath consumes. It keeps a scoreboard of destination registers for instructions issued but not yet written back. It stalls fetch/decode on read-after-write hazards, squashes decode on branch/jump mispredicts, and holds decode squashed for a configurable refill period after a redirect.

## Interface
Parameters:
- REGNOBITS, 6, register-number width (64 registers; every register, including 0, is writable and tracked)
- NSTAGES, 2, pipeline stages from issue (A) to register-file write (M inclusive); scoreboard depth, 1..4
- REFILL, 1, cycles decode stays squashed after a mispredict, 0..3

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- dec_valid  in  1  decode holds a real instruction
- dec_rs  in  REGNOBITS  first source register
- dec_rt  in  REGNOBITS  second source register
- dec_use_rs  in  1  instruction reads rs
- dec_use_rt  in  1  instruction reads rt (ALUR, branches, SW)
- dec_wrreg  in  1  instruction writes a register
- dec_wregno  in  REGNOBITS  destination register
- mispred  in  1  A-stage mispredict (already qualified by !isnop_A)
- stall_F  out  1  hold PC (mispred redirect still overrides)
- bubble_D  out  1  force isnop_D: instruction in D does not issue
- issue  out  1  instruction in D advances into A this cycle
- state  out  2  FSM state: 0 RUN, 1 STALL, 2 RECOVER

## Operation
- Scoreboard: NSTAGES entries {v, regno}. sb[0] is the instruction in A; sb[NSTAGES-1] is the one whose register write commits at the coming edge. Each edge shifts sb[i]→sb[i+1]. The last entry retires.
- Push at sb[0] each edge: {issue & dec_wrreg, dec_wregno}; otherwise v=0.
- hazard = dec_valid & ((dec_use_rs & any v & regno==dec_rs) | (dec_use_rt & any v & regno==dec_rt)), over all entries, including sb[NSTAGES-1].
- Register file is written on the edge and read combinationally, so there is no bypass. A match clears one cycle after the producer retires.
- Priority, highest first: reset, mispred, RECOVER, hazard, normal issue.
- mispred: bubble_D=1, stall_F=0, issue=0. Go to RECOVER with refill counter=REFILL; if REFILL=0, go to RUN. Scoreboard entries already issued are kept (the mispredicting instruction itself still commits).
- RECOVER: bubble_D=1, stall_F=0, issue=0. Counter decrements each cycle; go to RUN after the last count. A new mispred reloads the counter.
- hazard (RUN or STALL): stall_F=1, bubble_D=1, issue=0, state STALL. Stay in STALL while hazard holds; otherwise issue and go to RUN.
- Normal: stall_F=0, bubble_D=!dec_valid, issue=dec_valid.
- Outputs are combinational from inputs and registered state. State, counter and scoreboard are registered.

## Timing
- Reset (asynchronous): all v=0, state RUN, counter 0. While reset is high: bubble_D=1, issue=0, stall_F=0.
- Hazard latency: a dependent instruction directly after its producer stalls exactly NSTAGES cycles and issues on cycle NSTAGES+1.
- Mispredict: bubble_D is high in the mispred cycle plus REFILL following cycles.
- A mispred in the same cycle as a hazard: mispred wins, no stall.
- Reset asserted mid-STALL or mid-RECOVER: scoreboard cleared, state RUN on release.

## Configuration
- HAZ_STATS_EN defined: adds outputs stall_cnt[31:0] (cycles with stall_F=1) and squash_cnt[31:0] (cycles with bubble_D=1 caused by mispred or RECOVER). Both counters wrap at 2^32 and are cleared by reset.
- Not defined: the ports and counters are absent. Core behaviour is identical.

## Test plan
- ADDI r5 then ADD r6=r5+r7, NSTAGES=2 -> stall_F=1 for 2 cycles, issue=1 on cycle 3, state 1→0.
- Dependency two instructions apart (independent op between) -> 1 stall cycle; three apart -> 0 stalls.
- SW with dec_use_rt reading r9 while r9 is in sb[1] -> 1-cycle stall. Same instruction with dec_use_rt=0 -> no stall.
- mispred=1, REFILL=1 -> bubble_D=1 for 2 cycles, state 2 for 1 cycle. Earlier producer still retires and clears its hazard on schedule.
- mispred during STALL -> immediate RECOVER, stall_F=0. Reset pulse mid-RECOVER -> all outputs at reset values, state RUN after release.
- With HAZ_STATS_EN: 3 hazard stalls plus 1 mispred (REFILL=1) -> stall_cnt=3, squash_cnt=2. Reset -> both 0.

Source files
------------

// File: rtl/pipe_hazard_ctl.sv
// -----------------------------------------------------------------------------
// pipe_hazard_ctl
//
// Pipeline sequencing controller that sits beside the decode stage of the
// 32-bit core and owns the stall/flush signals the datapath consumes.
//
// A scoreboard holds the destination register of every instruction that has
// issued but not yet written back. A decode instruction that reads one of
// those registers is held (read-after-write stall). An A-stage mispredict
// squashes decode and keeps it squashed for REFILL further cycles while the
// front end refills from the redirected PC.
//
// Parameters
//   REGNOBITS  register-number width; every register, including 0, is tracked
//   NSTAGES    stages from issue (A) to register-file write (M), 1..4
//   REFILL     cycles decode stays squashed after a mispredict, 0..3
//
// Ports
//   clk, reset       clock; asynchronous active-high reset
//   dec_valid        decode holds a real instruction
//   dec_rs, dec_rt   source register numbers
//   dec_use_rs/rt    the instruction actually reads rs / rt
//   dec_wrreg        the instruction writes dec_wregno
//   mispred          A-stage mispredict (already qualified)
//   stall_F          hold the PC (a redirect still overrides it)
//   bubble_D         force the decode instruction to a nop
//   issue            decode instruction advances into A this cycle
//   state            FSM state: 0 RUN, 1 STALL, 2 RECOVER
//
// Optional feature (macro HAZ_STATS_EN): adds stall_cnt (cycles with
// stall_F=1) and squash_cnt (cycles squashed by mispred or RECOVER). Both wrap
// and are cleared by reset. Core behaviour is the same with or without it.
//
// Handshake: there is no valid/ready pair here. The instruction in decode
// moves into A exactly in the cycles where issue=1; in every other cycle
// bubble_D=1 and, when stall_F=1, fetch/decode must hold their contents.
// -----------------------------------------------------------------------------
module pipe_hazard_ctl #(
  parameter int REGNOBITS = 6,
  parameter int NSTAGES   = 2,
  parameter int REFILL    = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 dec_valid,
  input  logic [REGNOBITS-1:0] dec_rs,
  input  logic [REGNOBITS-1:0] dec_rt,
  input  logic                 dec_use_rs,
  input  logic                 dec_use_rt,
  input  logic                 dec_wrreg,
  input  logic [REGNOBITS-1:0] dec_wregno,
  input  logic                 mispred,
  output logic                 stall_F,
  output logic                 bubble_D,
  output logic                 issue,
  output logic [1:0]           state
`ifdef HAZ_STATS_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          squash_cnt
`endif
);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_STALL   = 2'd1,
    S_RECOVER = 2'd2
  } state_t;

  localparam logic [1:0] REFILL_CNT = 2'(REFILL);

  state_t               state_q, state_d;
  logic [1:0]           cnt_q, cnt_d;
  logic                 sb_v_q   [NSTAGES];
  logic [REGNOBITS-1:0] sb_reg_q [NSTAGES];
  logic                 rs_hit, rt_hit, hazard;

  // ---------------------------------------------------------------------------
  // Hazard detection. The register file is written on the edge and read
  // combinationally with no bypass, so the entry committing at the coming edge
  // (the last one) still counts as a hazard.
  // ---------------------------------------------------------------------------
  always_comb begin
    rs_hit = 1'b0;
    rt_hit = 1'b0;
    for (int i = 0; i < NSTAGES; i++) begin
      if (sb_v_q[i] && (sb_reg_q[i] == dec_rs)) rs_hit = 1'b1;
      if (sb_v_q[i] && (sb_reg_q[i] == dec_rt)) rt_hit = 1'b1;
    end
    hazard = dec_valid & ((dec_use_rs & rs_hit) | (dec_use_rt & rt_hit));
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_RUN;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state. Priority: mispred, RECOVER, hazard, normal issue.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (mispred) begin
      // A fresh mispredict always reloads the refill count, even in RECOVER.
      if (REFILL_CNT == 2'd0) begin
        state_d = S_RUN;
        cnt_d   = 2'd0;
      end else begin
        state_d = S_RECOVER;
        cnt_d   = REFILL_CNT;
      end
    end else if (state_q == S_RECOVER) begin
      if (cnt_q <= 2'd1) begin
        state_d = S_RUN;
        cnt_d   = 2'd0;
      end else begin
        cnt_d = cnt_q - 2'd1;
      end
    end else if (hazard) begin
      state_d = S_STALL;
    end else begin
      state_d = S_RUN;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs. Reset is included so the datapath sees a squashed decode
  // while reset is held, independent of the registered state.
  // ---------------------------------------------------------------------------
  always_comb begin
    stall_F  = 1'b0;
    bubble_D = 1'b1;
    issue    = 1'b0;
    if (reset) begin
      stall_F  = 1'b0;
    end else if (mispred || (state_q == S_RECOVER)) begin
      stall_F  = 1'b0;
    end else if (hazard) begin
      stall_F  = 1'b1;
    end else begin
      issue    = dec_valid;
      bubble_D = ~dec_valid;
    end
  end

  assign state = state_q;

  // ---------------------------------------------------------------------------
  // Scoreboard shift register. sb[0] is the instruction now in A; the last
  // entry retires at each edge. Entries already issued survive a mispredict:
  // the mispredicting instruction and its elders still commit.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NSTAGES; i++) begin
        sb_v_q[i]   <= 1'b0;
        sb_reg_q[i] <= '0;
      end
    end else begin
      sb_v_q[0]   <= issue & dec_wrreg;
      sb_reg_q[0] <= dec_wregno;
      for (int i = 1; i < NSTAGES; i++) begin
        sb_v_q[i]   <= sb_v_q[i-1];
        sb_reg_q[i] <= sb_reg_q[i-1];
      end
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] stall_cnt_q, squash_cnt_q;
  logic        squash_now;

  // Only squashes caused by a redirect count; idle or stalled bubbles do not.
  assign squash_now = ~reset & (mispred | (state_q == S_RECOVER));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q  <= 32'd0;
      squash_cnt_q <= 32'd0;
    end else begin
      if (stall_F)    stall_cnt_q  <= stall_cnt_q + 32'd1;
      if (squash_now) squash_cnt_q <= squash_cnt_q + 32'd1;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign squash_cnt = squash_cnt_q;
`endif

endmodule
